// File: rtl/tri_bbox_scanner_if.sv
// Triangle in / sample points out bundle for tri_bbox_scanner.
// slave: the scanner itself; master: triangle source and sample consumer.
interface tri_bbox_scanner_if #(
    parameter int unsigned COORD_WIDTH = 32,
    parameter int unsigned H_RES       = 320,
    parameter int unsigned V_RES       = 180
);
    localparam int unsigned HW = $clog2(H_RES);
    localparam int unsigned VW = $clog2(V_RES);

    logic [2:0][COORD_WIDTH-1:0] tri_a;
    logic [2:0][COORD_WIDTH-1:0] tri_b;
    logic [2:0][COORD_WIDTH-1:0] tri_c;
    logic                        tri_valid;
    logic                        tri_ready;
    logic                        stall_in;
    logic                        bary_init;
    logic                        bary_init_done;
    logic                        bary_done;
    logic [2:0][COORD_WIDTH-1:0] a_out;
    logic [2:0][COORD_WIDTH-1:0] b_out;
    logic [2:0][COORD_WIDTH-1:0] c_out;
    logic [2:0][COORD_WIDTH-1:0] p_out;
    logic                        p_valid;
    logic [HW-1:0]               hcount_out;
    logic [VW-1:0]               vcount_out;
    logic                        pix_valid_out;
    logic                        tri_done;
    logic                        tri_skipped;

    modport slave (
        input  tri_a, tri_b, tri_c, tri_valid, stall_in, bary_init_done, bary_done,
        output tri_ready, bary_init, a_out, b_out, c_out, p_out, p_valid,
               hcount_out, vcount_out, pix_valid_out, tri_done, tri_skipped
    );

    modport master (
        output tri_a, tri_b, tri_c, tri_valid, stall_in, bary_init_done, bary_done,
        input  tri_ready, bary_init, a_out, b_out, c_out, p_out, p_valid,
               hcount_out, vcount_out, pix_valid_out, tri_done, tri_skipped
    );
endinterface

// File: rtl/tri_bbox_scanner.sv
// Rasterizer front end: clamped bounding box of one triangle, barycentric init, row-major sample scan.
// Optional macro PIXEL_CENTER_EN: sample points sit at pixel centres (+0.5) instead of corners.
module tri_bbox_scanner #(
    parameter int unsigned COORD_WIDTH = 32,
    parameter int unsigned H_RES       = 320,
    parameter int unsigned V_RES       = 180,
    parameter int unsigned LATENCY     = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    tri_bbox_scanner_if.slave bus
);
    localparam int unsigned FRAC = COORD_WIDTH / 2;
    localparam int unsigned HW   = $clog2(H_RES);
    localparam int unsigned VW   = $clog2(V_RES);
    localparam int unsigned DW   = $clog2(LATENCY + 1);
    localparam logic signed [COORD_WIDTH-1:0] X_LIM = COORD_WIDTH'(H_RES - 1);
    localparam logic signed [COORD_WIDTH-1:0] Y_LIM = COORD_WIDTH'(V_RES - 1);
`ifdef PIXEL_CENTER_EN
    localparam logic [COORD_WIDTH-1:0] SAMPLE_OFS = COORD_WIDTH'(1) << (FRAC - 1);
`else
    localparam logic [COORD_WIDTH-1:0] SAMPLE_OFS = '0;
`endif

    typedef logic [2:0][COORD_WIDTH-1:0] vec3_t;
    typedef enum logic [2:0] {S_IDLE, S_BBOX, S_INIT, S_WAIT_INIT, S_SCAN, S_DRAIN, S_DONE} state_t;

    function automatic logic signed [COORD_WIDTH-1:0] floor_fx(input logic [COORD_WIDTH-1:0] v);
        return $signed(v) >>> FRAC;
    endfunction

    function automatic logic signed [COORD_WIDTH-1:0] min3(input logic signed [COORD_WIDTH-1:0] a,
                                                           input logic signed [COORD_WIDTH-1:0] b,
                                                           input logic signed [COORD_WIDTH-1:0] c);
        logic signed [COORD_WIDTH-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [COORD_WIDTH-1:0] max3(input logic signed [COORD_WIDTH-1:0] a,
                                                           input logic signed [COORD_WIDTH-1:0] b,
                                                           input logic signed [COORD_WIDTH-1:0] c);
        logic signed [COORD_WIDTH-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    state_t                    r_state;
    state_t                    w_state_nxt;
    vec3_t                     r_a, r_b, r_c, r_p_out;
    logic [HW-1:0]             r_xmin, r_xmax, r_x, r_px;
    logic [VW-1:0]             r_ymin, r_ymax, r_y, r_py;
    logic [DW-1:0]             r_drain;
    logic                      r_tri_ready, r_bary_init, r_tri_done, r_tri_skipped, r_p_valid;
    logic [LATENCY-1:0]        r_dly_v;
    logic [LATENCY-1:0][HW-1:0] r_dly_x;
    logic [LATENCY-1:0][VW-1:0] r_dly_y;

    logic signed [COORD_WIDTH-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
    logic                          w_box_off, w_last;
    logic                          w_accept, w_box_load, w_skip, w_scan_start, w_emit;
    logic [HW-1:0]                 w_cxmin, w_cxmax;
    logic [VW-1:0]                 w_cymin, w_cymax;

    // Integer bounding box of the latched vertices, then clamped to the screen
    assign w_xmin    = min3(floor_fx(r_a[0]), floor_fx(r_b[0]), floor_fx(r_c[0]));
    assign w_xmax    = max3(floor_fx(r_a[0]), floor_fx(r_b[0]), floor_fx(r_c[0]));
    assign w_ymin    = min3(floor_fx(r_a[1]), floor_fx(r_b[1]), floor_fx(r_c[1]));
    assign w_ymax    = max3(floor_fx(r_a[1]), floor_fx(r_b[1]), floor_fx(r_c[1]));
    assign w_box_off = (w_xmax < 0) || (w_ymax < 0) || (w_xmin > X_LIM) || (w_ymin > Y_LIM);
    assign w_cxmin   = (w_xmin < 0) ? '0 : HW'(w_xmin);
    assign w_cymin   = (w_ymin < 0) ? '0 : VW'(w_ymin);
    assign w_cxmax   = (w_xmax > X_LIM) ? HW'(H_RES - 1) : HW'(w_xmax);
    assign w_cymax   = (w_ymax > Y_LIM) ? VW'(V_RES - 1) : VW'(w_ymax);
    assign w_last    = (r_x == r_xmax) && (r_y == r_ymax);

    always_ff @(posedge clk_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (bus.tri_valid) w_state_nxt = S_BBOX;
            S_BBOX:      w_state_nxt = w_box_off ? S_DONE : S_INIT;
            S_INIT:      w_state_nxt = S_WAIT_INIT;
            S_WAIT_INIT: begin
                if (bus.bary_init_done) w_state_nxt = S_SCAN;
                else if (bus.bary_done) w_state_nxt = S_DONE;
            end
            S_SCAN:      if (!bus.stall_in && w_last) w_state_nxt = S_DRAIN;
            S_DRAIN:     if (r_drain == DW'(LATENCY - 1)) w_state_nxt = S_DONE;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept     = 1'b0;
        w_box_load   = 1'b0;
        w_skip       = 1'b0;
        w_scan_start = 1'b0;
        w_emit       = 1'b0;
        case (r_state)
            S_IDLE:      w_accept = bus.tri_valid;
            S_BBOX:      begin
                w_box_load = !w_box_off;
                w_skip     = w_box_off;
            end
            S_WAIT_INIT: begin
                w_scan_start = bus.bary_init_done;
                w_skip       = !bus.bary_init_done && bus.bary_done;
            end
            S_SCAN:      w_emit = !bus.stall_in;
            default:     ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_tri_ready   <= 1'b1;
            r_bary_init   <= 1'b0;
            r_tri_done    <= 1'b0;
            r_tri_skipped <= 1'b0;
            r_p_valid     <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_p_out       <= '0;
            r_xmin        <= '0;
            r_xmax        <= '0;
            r_ymin        <= '0;
            r_ymax        <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_px          <= '0;
            r_py          <= '0;
            r_drain       <= '0;
        end else begin
            r_tri_ready <= (w_state_nxt == S_IDLE);
            r_bary_init <= (w_state_nxt == S_INIT);
            r_tri_done  <= (w_state_nxt == S_DONE);
            r_p_valid   <= w_emit;
            r_drain     <= (r_state == S_DRAIN) ? r_drain + DW'(1) : '0;
            if (w_accept) begin
                r_a           <= {COORD_WIDTH'(0), bus.tri_a[1], bus.tri_a[0]};
                r_b           <= {COORD_WIDTH'(0), bus.tri_b[1], bus.tri_b[0]};
                r_c           <= {COORD_WIDTH'(0), bus.tri_c[1], bus.tri_c[0]};
                r_tri_skipped <= 1'b0;
            end
            if (w_skip) r_tri_skipped <= 1'b1;
            if (w_box_load) begin
                r_xmin <= w_cxmin;
                r_xmax <= w_cxmax;
                r_ymin <= w_cymin;
                r_ymax <= w_cymax;
            end
            if (w_scan_start) begin
                r_x <= r_xmin;
                r_y <= r_ymin;
            end
            // Emit the current counter point and step row-major
            if (w_emit) begin
                r_p_out <= {COORD_WIDTH'(0),
                            (COORD_WIDTH'(r_y) << FRAC) + SAMPLE_OFS,
                            (COORD_WIDTH'(r_x) << FRAC) + SAMPLE_OFS};
                r_px    <= r_x;
                r_py    <= r_y;
                if (r_x == r_xmax) begin
                    r_x <= r_xmin;
                    r_y <= r_y + VW'(1);
                end else begin
                    r_x <= r_x + HW'(1);
                end
            end
        end
    end

    // Pixel coordinates ride alongside p_valid to meet the barycentric results
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_dly_v <= '0;
            r_dly_x <= '0;
            r_dly_y <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                r_dly_v[i] <= r_dly_v[i-1];
                r_dly_x[i] <= r_dly_x[i-1];
                r_dly_y[i] <= r_dly_y[i-1];
            end
            r_dly_v[0] <= r_p_valid;
            r_dly_x[0] <= r_px;
            r_dly_y[0] <= r_py;
        end
    end

    assign bus.tri_ready     = r_tri_ready;
    assign bus.bary_init     = r_bary_init;
    assign bus.tri_done      = r_tri_done;
    assign bus.tri_skipped   = r_tri_skipped;
    assign bus.a_out         = r_a;
    assign bus.b_out         = r_b;
    assign bus.c_out         = r_c;
    assign bus.p_out         = r_p_out;
    assign bus.p_valid       = r_p_valid;
    assign bus.pix_valid_out = r_dly_v[LATENCY-1];
    assign bus.hcount_out    = r_dly_x[LATENCY-1];
    assign bus.vcount_out    = r_dly_y[LATENCY-1];
endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Self-checking bench for tri_bbox_scanner: directed vector table, reset-mid-scan sequence, random triangles.
module tb_tri_bbox_scanner;
    localparam int unsigned CW  = 32;
    localparam int unsigned HR  = 320;
    localparam int unsigned VR  = 180;
    localparam int unsigned LAT = 8;
    localparam int          BUDGET = 70000;
`ifdef PIXEL_CENTER_EN
    localparam int SOFS = 32'h8000;
`else
    localparam int SOFS = 0;
`endif

    typedef struct {
        int x;
        int y;
    } pt_t;

    typedef struct {
        int ax, ay, bx, by, cx, cy;
        bit degen;
        int stall_mode;   // 0 none, 1 random, 2 three-cycle stall at x=4 of first row
        int exp_points;   // -1: take count from the model only
        bit exp_skip;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    pt_t  exp_q[$];

    always #5 clk = ~clk;

    tri_bbox_scanner_if #(.COORD_WIDTH(CW), .H_RES(HR), .V_RES(VR)) bus ();

    tri_bbox_scanner #(.COORD_WIDTH(CW), .H_RES(HR), .V_RES(VR), .LATENCY(LAT)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: integer box from pixel-level vertices, screen clip, row-major sample list
    task automatic build_model(input int ax, ay, bx, by, cx, cy, output bit off);
        int xmin, xmax, ymin, ymax;
        xmin = ax; xmax = ax; ymin = ay; ymax = ay;
        if (bx < xmin) xmin = bx;
        if (cx < xmin) xmin = cx;
        if (bx > xmax) xmax = bx;
        if (cx > xmax) xmax = cx;
        if (by < ymin) ymin = by;
        if (cy < ymin) ymin = cy;
        if (by > ymax) ymax = by;
        if (cy > ymax) ymax = cy;
        exp_q.delete();
        off = (xmax < 0) || (ymax < 0) || (xmin > int'(HR) - 1) || (ymin > int'(VR) - 1);
        if (!off) begin
            if (xmin < 0) xmin = 0;
            if (ymin < 0) ymin = 0;
            if (xmax > int'(HR) - 1) xmax = int'(HR) - 1;
            if (ymax > int'(VR) - 1) ymax = int'(VR) - 1;
            for (int y = ymin; y <= ymax; y++)
                for (int x = xmin; x <= xmax; x++)
                    exp_q.push_back('{x: x, y: y});
        end
    endtask

    task automatic run_tri(input string tag, input vec_t v);
        bit          off, done, skip, stalled_once;
        int          cyc, inits, first_p, first_pix, gap, maxgap, resp, stall_left, ofs_bad, z_bad, bad;
        int          fr[6];
        logic [31:0] ea;
        pt_t         got_p[$];
        pt_t         got_pix[$];

        build_model(v.ax, v.ay, v.bx, v.by, v.cx, v.cy, off);
        if (v.degen) exp_q.delete();
        for (int i = 0; i < 6; i++) fr[i] = int'($urandom_range(0, 65535));

        @(negedge clk);
        check({tag, "_ready_idle"}, bus.tri_ready, 1);
        bus.tri_a[0] = 32'(v.ax * 65536 + fr[0]);
        bus.tri_a[1] = 32'(v.ay * 65536 + fr[1]);
        bus.tri_b[0] = 32'(v.bx * 65536 + fr[2]);
        bus.tri_b[1] = 32'(v.by * 65536 + fr[3]);
        bus.tri_c[0] = 32'(v.cx * 65536 + fr[4]);
        bus.tri_c[1] = 32'(v.cy * 65536 + fr[5]);
        bus.tri_a[2] = $urandom;
        bus.tri_b[2] = $urandom;
        bus.tri_c[2] = $urandom;
        bus.tri_valid = 1'b1;
        @(negedge clk);
        bus.tri_valid = 1'b0;
        check({tag, "_ready_busy"}, bus.tri_ready, 0);
        ea = 32'(v.ax * 65536 + fr[0]);
        check({tag, "_a_out_x"}, bus.a_out[0], ea);
        check({tag, "_a_out_z"}, bus.a_out[2], 0);

        done = 0; skip = 0; stalled_once = 0; cyc = 0; inits = 0;
        first_p = -1; first_pix = -1; gap = 0; maxgap = 0; resp = -1;
        stall_left = 0; ofs_bad = 0; z_bad = 0;
        while (!done && cyc < BUDGET) begin
            if (bus.bary_init) begin
                inits++;
                resp = int'($urandom_range(1, 4));
            end
            if (bus.p_valid) begin
                if (got_p.size() > 0 && gap > maxgap) maxgap = gap;
                gap = 0;
                if (first_p < 0) first_p = cyc;
                got_p.push_back('{x: int'($signed(bus.p_out[0])) >>> 16,
                                  y: int'($signed(bus.p_out[1])) >>> 16});
                if (int'(bus.p_out[0][15:0]) != SOFS || int'(bus.p_out[1][15:0]) != SOFS) ofs_bad++;
                if (bus.p_out[2] != 0) z_bad++;
                if (v.stall_mode == 2 && !stalled_once && got_p[$].x == 3) begin
                    stalled_once = 1;
                    stall_left   = 3;
                end
            end else if (got_p.size() > 0) begin
                gap++;
            end
            if (bus.pix_valid_out) begin
                if (first_pix < 0) first_pix = cyc;
                got_pix.push_back('{x: int'(bus.hcount_out), y: int'(bus.vcount_out)});
            end
            if (bus.tri_done) begin
                done = 1;
                skip = bus.tri_skipped;
            end
            bus.bary_init_done = 1'b0;
            bus.bary_done      = 1'b0;
            if (resp == 0) begin
                if (v.degen) begin
                    bus.bary_done = 1'b1;
                end else begin
                    bus.bary_init_done = 1'b1;
                    bus.bary_done      = 1'($urandom_range(0, 1));
                end
                resp = -1;
            end else if (resp > 0) begin
                resp--;
            end
            if (v.stall_mode == 1) begin
                bus.stall_in = ($urandom_range(0, 3) == 0);
            end else if (stall_left > 0) begin
                bus.stall_in = 1'b1;
                stall_left--;
            end else begin
                bus.stall_in = 1'b0;
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.stall_in       = 1'b0;
        bus.bary_init_done = 1'b0;
        bus.bary_done      = 1'b0;

        check({tag, "_done_seen"}, done, 1);
        check({tag, "_skipped"}, skip, v.exp_skip);
        check({tag, "_bary_inits"}, inits, (off ? 0 : 1));
        check({tag, "_n_points"}, got_p.size(), exp_q.size());
        if (v.exp_points >= 0) check({tag, "_n_points_tbl"}, got_p.size(), v.exp_points);
        bad = 0;
        for (int i = 0; i < got_p.size() && i < exp_q.size(); i++)
            if (got_p[i] != exp_q[i]) bad++;
        check({tag, "_point_order"}, bad, 0);
        check({tag, "_n_pix"}, got_pix.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < got_pix.size() && i < exp_q.size(); i++)
            if (got_pix[i] != exp_q[i]) bad++;
        check({tag, "_pix_order"}, bad, 0);
        if (exp_q.size() > 0) begin
            check({tag, "_pix_latency"}, first_pix - first_p, LAT);
            check({tag, "_sample_ofs"}, ofs_bad, 0);
            check({tag, "_p_out_z"}, z_bad, 0);
            if (got_pix.size() > 0) begin
                check({tag, "_last_h"}, got_pix[$].x, exp_q[$].x);
                check({tag, "_last_v"}, got_pix[$].y, exp_q[$].y);
            end
        end
        if (v.stall_mode == 2) check({tag, "_stall_gap"}, maxgap, 3);
        @(negedge clk);
        check({tag, "_ready_after"}, bus.tri_ready, 1);
        check({tag, "_skip_hold"}, bus.tri_skipped, v.exp_skip);
    endtask

    vec_t tbl[8];

    initial begin
        int bad, seen, cyc, resp;
        bit off;
        vec_t rv;

        tbl[0] = '{ax: 2,   ay: 3,   bx: 5,   by: 3,   cx: 2,   cy: 6,   degen: 0, stall_mode: 0, exp_points: 16,    exp_skip: 0};
        tbl[1] = '{ax: -10, ay: 5,   bx: -3,  by: 5,   cx: -5,  cy: 9,   degen: 0, stall_mode: 0, exp_points: 0,     exp_skip: 1};
        tbl[2] = '{ax: 2,   ay: 3,   bx: 5,   by: 3,   cx: 2,   cy: 6,   degen: 1, stall_mode: 0, exp_points: 0,     exp_skip: 1};
        tbl[3] = '{ax: 2,   ay: 3,   bx: 5,   by: 3,   cx: 2,   cy: 6,   degen: 0, stall_mode: 2, exp_points: 16,    exp_skip: 0};
        tbl[4] = '{ax: 7,   ay: 7,   bx: 7,   by: 7,   cx: 7,   cy: 7,   degen: 0, stall_mode: 0, exp_points: 1,     exp_skip: 0};
        tbl[5] = '{ax: 10,  ay: 180, bx: 20,  by: 185, cx: 15,  cy: 200, degen: 0, stall_mode: 0, exp_points: 0,     exp_skip: 1};
        tbl[6] = '{ax: 318, ay: 178, bx: 330, by: 190, cx: 319, cy: 200, degen: 0, stall_mode: 1, exp_points: 4,     exp_skip: 0};
        tbl[7] = '{ax: -4,  ay: -4,  bx: 330, by: 0,   cx: 0,   cy: 200, degen: 0, stall_mode: 0, exp_points: 57600, exp_skip: 0};

        bus.tri_a = '0; bus.tri_b = '0; bus.tri_c = '0;
        bus.tri_valid = 1'b0; bus.stall_in = 1'b0;
        bus.bary_init_done = 1'b0; bus.bary_done = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tri_ready", bus.tri_ready, 1);
        check("rst_p_valid", bus.p_valid, 0);
        check("rst_bary_init", bus.bary_init, 0);
        check("rst_tri_done", bus.tri_done, 0);
        check("rst_tri_skipped", bus.tri_skipped, 0);
        check("rst_pix_valid", bus.pix_valid_out, 0);
        check("rst_p_out_x", bus.p_out[0], 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_tri($sformatf("vec%0d", i), tbl[i]);

        // Reset while scanning: abort, no done pulse, no stale delayed pixels
        build_model(0, 0, 20, 0, 0, 20, off);
        @(negedge clk);
        bus.tri_a[0] = 32'(0);          bus.tri_a[1] = 32'(0);
        bus.tri_b[0] = 32'(20 * 65536); bus.tri_b[1] = 32'(0);
        bus.tri_c[0] = 32'(0);          bus.tri_c[1] = 32'(20 * 65536);
        bus.tri_valid = 1'b1;
        @(negedge clk);
        bus.tri_valid = 1'b0;
        seen = 0; cyc = 0; resp = -1;
        while (seen < 5 && cyc < 200) begin
            bus.bary_init_done = (resp == 0);
            if (resp >= 0) resp--;
            if (bus.bary_init) resp = 1;
            if (bus.p_valid) seen++;
            @(negedge clk);
            cyc++;
        end
        bus.bary_init_done = 1'b0;
        check("rstscan_reached_scan", seen, 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstscan_tri_ready", bus.tri_ready, 1);
        check("rstscan_p_valid", bus.p_valid, 0);
        check("rstscan_pix_valid", bus.pix_valid_out, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < int'(LAT) + 2; i++) begin
            @(negedge clk);
            if (bus.pix_valid_out || bus.tri_done || bus.p_valid) bad++;
        end
        check("rstscan_quiet", bad, 0);

        for (int i = 0; i < 12; i++) begin
            rv.ax = int'($urandom_range(0, 380)) - 30;
            rv.ay = int'($urandom_range(0, 240)) - 30;
            rv.bx = rv.ax + int'($urandom_range(0, 16)) - 8;
            rv.by = rv.ay + int'($urandom_range(0, 16)) - 8;
            rv.cx = rv.ax + int'($urandom_range(0, 16)) - 8;
            rv.cy = rv.ay + int'($urandom_range(0, 16)) - 8;
            rv.degen = ($urandom_range(0, 5) == 0);
            rv.stall_mode = 1;
            rv.exp_points = -1;
            build_model(rv.ax, rv.ay, rv.bx, rv.by, rv.cx, rv.cy, off);
            rv.exp_skip = off || rv.degen;
            run_tri($sformatf("rnd%0d", i), rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
